// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder and its block buffer.
package sha256_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FILL = 3'd0;
  localparam state_t ST_PAD  = 3'd1;
  localparam state_t ST_LEN  = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_SEND = 3'd4;

  localparam int         BLOCK_BYTES     = 64;
  localparam int         LEN_OFS         = 56;
  localparam int         WORDS_PER_BLOCK = 16;
  localparam logic [7:0] PAD_BYTE        = 8'h80;

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-stream input and 32-bit block-word output of the padder, bundled for port connection.
interface sha256_padder_if;

  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        input_ready;
  logic [31:0] data_prepro;
  logic        data_load;
  logic        first_block;
  logic        last_block;

  modport slave (
    input  in_byte, in_valid, in_last, input_ready,
    output in_ready, data_prepro, data_load, first_block, last_block
  );

  modport master (
    output in_byte, in_valid, in_last, input_ready,
    input  in_ready, data_prepro, data_load, first_block, last_block
  );

endinterface

// File: rtl/sha256_blk_buf.sv
// 64-byte block buffer: single byte write, parallel 8-byte length write into 56..63,
// and a big-endian 32-bit word read.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        len_wr,
  input  logic [63:0] len_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [7:0] mem [BLOCK_BYTES];

  generate
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;
      assign mem[gi] = byte_reg;
      if (gi >= LEN_OFS) begin : g_len
        // Length field is big-endian: byte 56 takes bits 63:56.
        localparam int SH = (BLOCK_BYTES - 1 - gi) * 8;
        always_ff @(posedge clk) begin
          if (len_wr)
            byte_reg <= len_data[SH +: 8];
          else if (wr_en && wr_addr == 6'(gi))
            byte_reg <= wr_data;
        end
      end else begin : g_dat
        always_ff @(posedge clk) begin
          if (wr_en && wr_addr == 6'(gi))
            byte_reg <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = {mem[{rd_addr, 2'd0}], mem[{rd_addr, 2'd1}],
                    mem[{rd_addr, 2'd2}], mem[{rd_addr, 2'd3}]};

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: buffers a byte stream into 512-bit blocks, appends marker,
// zero fill and bit length, then streams each block as 16 words to the hash core.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic           clk,
  input logic           rst_n,
  sha256_padder_if.slave bus
);

  state_t           state_reg, state_next;
  logic [5:0]       idx_reg, idx_next;
  logic [LEN_W-1:0] bitcnt_reg, bitcnt_next;
  logic [3:0]       wcnt_reg, wcnt_next;
  logic             first_reg, first_next;
  logic             two_blk_reg, two_blk_next;
  logic             mark_done_reg, mark_done_next;
  logic             final_reg, final_next;

  logic             in_ready_reg, in_ready_next;
  logic             data_load_reg, data_load_next;
  logic             first_block_reg, first_block_next;
  logic             last_block_reg, last_block_next;
  logic [31:0]      data_prepro_reg, data_prepro_next;

  logic             accept;
  logic             wr_en;
  logic             len_wr;
  logic [7:0]       wr_data;
  logic [63:0]      len64;
  logic [31:0]      rd_word;

  // in_ready_reg is high exactly while in FILL (outside the cycle after reset).
  assign accept = bus.in_valid && in_ready_reg;

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bitcnt_reg;
  end

  sha256_blk_buf u_buf (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (idx_reg),
    .wr_data  (wr_data),
    .len_wr   (len_wr),
    .len_data (len64),
    .rd_addr  (wcnt_next),
    .rd_data  (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_FILL;
      idx_reg         <= '0;
      bitcnt_reg      <= '0;
      wcnt_reg        <= '0;
      first_reg       <= 1'b1;
      two_blk_reg     <= 1'b0;
      mark_done_reg   <= 1'b0;
      final_reg       <= 1'b0;
      in_ready_reg    <= 1'b0;
      data_load_reg   <= 1'b0;
      first_block_reg <= 1'b0;
      last_block_reg  <= 1'b0;
      data_prepro_reg <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      bitcnt_reg      <= bitcnt_next;
      wcnt_reg        <= wcnt_next;
      first_reg       <= first_next;
      two_blk_reg     <= two_blk_next;
      mark_done_reg   <= mark_done_next;
      final_reg       <= final_next;
      in_ready_reg    <= in_ready_next;
      data_load_reg   <= data_load_next;
      first_block_reg <= first_block_next;
      last_block_reg  <= last_block_next;
      data_prepro_reg <= data_prepro_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    bitcnt_next    = bitcnt_reg;
    wcnt_next      = wcnt_reg;
    first_next     = first_reg;
    two_blk_next   = two_blk_reg;
    mark_done_next = mark_done_reg;
    final_next     = final_reg;
    case (state_reg)
      ST_FILL: begin
        if (accept) begin
          idx_next    = idx_reg + 6'd1;
          bitcnt_next = bitcnt_reg + LEN_W'(8);
          if (bus.in_last) begin
            mark_done_next = 1'b0;
            // A message ending on byte 63 leaves no room for the marker in this block.
            if (idx_reg == 6'(BLOCK_BYTES - 1)) begin
              state_next   = ST_WAIT;
              two_blk_next = 1'b1;
              final_next   = 1'b0;
            end else begin
              state_next = ST_PAD;
            end
          end else if (idx_reg == 6'(BLOCK_BYTES - 1)) begin
            state_next = ST_WAIT;
            final_next = 1'b0;
          end
        end
      end
      ST_PAD: begin
        mark_done_next = 1'b1;
        if (idx_reg == 6'(LEN_OFS - 1)) begin
          state_next = ST_LEN;
        end else if (idx_reg == 6'(BLOCK_BYTES - 1)) begin
          state_next   = ST_WAIT;
          two_blk_next = 1'b1;
          final_next   = 1'b0;
        end else begin
          idx_next = idx_reg + 6'd1;
        end
      end
      ST_LEN: begin
        state_next = ST_WAIT;
        final_next = 1'b1;
      end
      ST_WAIT: begin
        if (bus.input_ready) begin
          state_next = ST_SEND;
          wcnt_next  = '0;
        end
      end
      ST_SEND: begin
        wcnt_next = wcnt_reg + 4'd1;
        if (wcnt_reg == 4'(WORDS_PER_BLOCK - 1)) begin
          idx_next   = '0;
          first_next = 1'b0;
          if (final_reg) begin
            state_next     = ST_FILL;
            bitcnt_next    = '0;
            first_next     = 1'b1;
            two_blk_next   = 1'b0;
            mark_done_next = 1'b0;
            final_next     = 1'b0;
          end else if (two_blk_reg) begin
            state_next = ST_PAD;
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Outputs are registered from next-state so the first word shows one cycle after WAIT.
  always_comb begin
    wr_en            = accept || (state_reg == ST_PAD);
    wr_data          = (state_reg == ST_PAD) ? (mark_done_reg ? 8'h00 : PAD_BYTE) : bus.in_byte;
    len_wr           = (state_reg == ST_LEN);
    in_ready_next    = (state_next == ST_FILL);
    data_load_next   = (state_next == ST_SEND);
    data_prepro_next = data_load_next ? rd_word : 32'h0;
    first_block_next = data_load_next && first_reg;
    last_block_next  = data_load_next && final_reg;
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.data_load   = data_load_reg;
  assign bus.data_prepro = data_prepro_reg;
  assign bus.first_block = first_block_reg;
  assign bus.last_block  = last_block_reg;

endmodule
